seq_multiplier_n: RTL and testbench
===================================

Name: seq_multiplier_n

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 8-bit lab multiplier.
- Supports any operand width, signed (two's-complement, subtract-on-last-step) or unsigned mode, and an explicit Busy/Done handshake.
- Sits behind the input synchronizers (all inputs already synchronous to Clk, active-high).
- Its A/B outputs drive the hex display and debug buses.

Parameters:
- WIDTH, 8, operand width in bits; minimum 2. Product is 2*WIDTH bits in {A,B}.
- CNT_W, $clog2(WIDTH), step-counter width; derived, do not override.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Execute  in  1  level; starts one multiply per assertion.
- Load_B  in  1  load B <= Din when idle.
- Clear_A  in  1  clear A and X when idle.
- Signed_Mode  in  1  1 = two's-complement, 0 = unsigned; sampled at start.
- Din  in  WIDTH  multiplicand source S, and B load data.
- Aval  out  WIDTH  A register (product high half).
- Bval  out  WIDTH  B register (multiplier, then product low half).
- Xval  out  1  sign/carry extension bit X.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset: asynchronous; while asserted, A=0, B=0, X=0, S=0, count=0, state=IDLE, Busy=0, Done=0. Applies equally mid-run: the run is aborted and no Done is issued.
- States are IDLE, RUN and HOLD.
- IDLE:
  - Priority is Execute > Load_B > Clear_A; only one action per cycle.
  - Execute=1: S<=Din, mode<=Signed_Mode, A<=0, X<=0, count<=0, go to RUN. B is kept as the multiplier.
  - Load_B=1: B<=Din.
  - Clear_A=1: A<=0, X<=0.
- RUN: one add+shift per cycle, driven by M=B[0].
  - Sum: if M=1, sum = {X,A} + ext(S); on the final step (count==WIDTH-1) in signed mode it is {X,A} - ext(S). If M=0, sum = {X,A}.
  - ext(S): sign-extended to WIDTH+1 bits in signed mode, zero-extended in unsigned mode.
  - Shift: {X,A,B} <= {fill, sum, B[WIDTH-1:1]}, where sum[0] goes into B[WIDTH-1] and the WIDTH+1-bit sum lands in {X,A}.
  - fill = sum[WIDTH] in signed mode; 0 in unsigned mode.
  - count increments each step. After the step with count==WIDTH-1, go to HOLD.
- Latency: Execute seen at edge k; RUN occupies edges k+1..k+WIDTH; the product is valid at Aval/Bval from edge k+WIDTH onward.
  - Busy is high for exactly WIDTH cycles.
  - Done is high for exactly one cycle, the first HOLD cycle.
- HOLD: stay until Execute==0, then go to IDLE. A held Execute therefore yields exactly one multiply. Load_B and Clear_A are ignored in HOLD.
- Ignored during RUN: Execute, Load_B, Clear_A, Din and Signed_Mode changes.
- Chaining: a new Execute multiplies the current B (low product half) by the new Din. A is cleared at start; there is no accumulate.
- Results: unsigned result is the full 2*WIDTH-bit product. Signed result is the exact two's-complement product, including the most-negative × most-negative case (-2^(W-1))^2, which must not overflow.
- Aval, Bval and Xval are direct register outputs (no combinational path from inputs).

Decomposition:
- Package mult_pkg holds:
  - state typedef enum logic [1:0] {IDLE, RUN, HOLD};
  - localparam for the minimum WIDTH check, plus an elaboration-time assertion that WIDTH >= 2.
- One sub-module, add_sub_w1: a WIDTH+1-bit combinational adder/subtractor (inputs a, b, sub; output s). It is instantiated once; the shift register and FSM stay in the top.

Test Plan:
- WIDTH=8, unsigned, Load_B with Din=0xFF, then Execute with Din=0xFF -> Busy high for 8 cycles, then a Done pulse; Aval=0xFE, Bval=0x01.
- WIDTH=8, signed, B=0x07, Execute with Din=0xC5 (-59) -> {A,B}=0xFE63 (-413); a second Execute with Din=0x02 -> {A,B}=0x00C6, chaining on B=0x63.
- WIDTH=8, signed, B=0x80, S=0x80 -> {A,B}=0x4000. Also B=0xFF, S=0xFF -> 0x0001.
- Execute held high for 40 cycles -> exactly one Done pulse and one product; Load_B asserted during HOLD has no effect on B.
- Reset asserted asynchronously at the 4th RUN cycle -> A=B=X=0 immediately, Busy=0, no Done; the next Execute runs normally.
- WIDTH=4, signed, B=0x9 (-7), S=0x7 -> {A,B}=0xCF (-49); unsigned with the same operands -> 0x3F (63).

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared state type and width limit for the sequential multiplier
package mult_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
   localparam int MIN_WIDTH = 2;
endpackage

// File: rtl/add_sub_w1.sv
// add_sub_w1: combinational W-bit adder/subtractor used for the extended {X,A} accumulator
module add_sub_w1 #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] s
);
   assign s = sub ? a - b : a + b;
endmodule

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: parametrised shift-add multiplier, signed/unsigned, with Busy/Done handshake
module seq_multiplier_n
   import mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Execute,
   input  logic             Load_B,
   input  logic             Clear_A,
   input  logic             Signed_Mode,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             Xval,
   output logic             Busy,
   output logic             Done
);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             x_q, x_d, mode_q, mode_d, done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last;
   logic [WIDTH:0]   addend, sum;

   if (WIDTH < MIN_WIDTH) begin : g_width_chk
      $error("seq_multiplier_n: WIDTH must be at least %0d", MIN_WIDTH);
   end

   assign last   = cnt_q == CNT_W'(WIDTH - 1);
   assign addend = b_q[0] ? {mode_q & s_q[WIDTH-1], s_q} : '0;

   // signed mode subtracts on the last step: the multiplier MSB carries weight -2^(W-1)
   add_sub_w1 #(.W(WIDTH + 1)) u_add_sub (
      .a  ({x_q, a_q}),
      .b  (addend),
      .sub(b_q[0] & last & mode_q),
      .s  (sum)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         x_q     <= 1'b0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         x_q     <= x_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = (state_q == IDLE && Execute)  ? RUN  :
                (state_q == RUN && last)      ? HOLD :
                (state_q == HOLD && !Execute) ? IDLE : state_q;
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      x_d    = x_q;
      mode_d = mode_q;
      cnt_d  = cnt_q;
      done_d = state_q == RUN && last;
      if (state_q == IDLE) begin
         if (Execute) begin
            s_d    = Din;
            mode_d = Signed_Mode;
            a_d    = '0;
            x_d    = 1'b0;
            cnt_d  = '0;
         end else if (Load_B) begin
            b_d = Din;
         end else if (Clear_A) begin
            a_d = '0;
            x_d = 1'b0;
         end
      end else if (state_q == RUN) begin
         x_d   = mode_q & sum[WIDTH];
         a_d   = sum[WIDTH:1];
         b_d   = {sum[0], b_q[WIDTH-1:1]};
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      Aval = a_q;
      Bval = b_q;
      Xval = x_q;
      Busy = state_q == RUN;
      Done = done_q;
   end
endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb_seq_multiplier_n: directed vectors for the 8-bit and 4-bit sequential multiplier
module tb_seq_multiplier_n;
   logic       Clk = 1'b0, Reset = 1'b1;
   logic       e8 = 0, l8 = 0, c8 = 0, sm8 = 0;
   logic [7:0] d8 = '0, a8, b8;
   logic       x8, busy8, done8;
   logic       e4 = 0, l4 = 0, c4 = 0, sm4 = 0;
   logic [3:0] d4 = '0, a4, b4;
   logic       x4, busy4, done4;
   int         n_chk = 0, n_fail = 0;
   int         nb, nd;

   always #5 Clk = ~Clk;

   seq_multiplier_n #(.WIDTH(8)) u8 (
      .Clk(Clk), .Reset(Reset), .Execute(e8), .Load_B(l8), .Clear_A(c8), .Signed_Mode(sm8),
      .Din(d8), .Aval(a8), .Bval(b8), .Xval(x8), .Busy(busy8), .Done(done8)
   );

   seq_multiplier_n #(.WIDTH(4)) u4 (
      .Clk(Clk), .Reset(Reset), .Execute(e4), .Load_B(l4), .Clear_A(c4), .Signed_Mode(sm4),
      .Din(d4), .Aval(a4), .Bval(b4), .Xval(x4), .Busy(busy4), .Done(done4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load8(input logic [7:0] v);
      l8 = 1; d8 = v;
      @(negedge Clk);
      l8 = 0;
   endtask

   task automatic load4(input logic [3:0] v);
      l4 = 1; d4 = v;
      @(negedge Clk);
      l4 = 0;
   endtask

   // scrambles Din/mode while running, then counts Busy cycles until the Done pulse
   task automatic run8(input logic sm, input logic [7:0] din, output int b, output int d);
      e8 = 1; d8 = din; sm8 = sm;
      @(negedge Clk);
      e8 = 0; d8 = 8'h5A; sm8 = ~sm; l8 = 1; c8 = 1;
      b = 0; d = 0;
      for (int i = 0; i < 40 && d == 0; i++) begin
         if (busy8) b++;
         if (done8) d++;
         @(negedge Clk);
      end
      l8 = 0; c8 = 0;
   endtask

   task automatic run4(input logic sm, input logic [3:0] din, output int b, output int d);
      e4 = 1; d4 = din; sm4 = sm;
      @(negedge Clk);
      e4 = 0;
      b = 0; d = 0;
      for (int i = 0; i < 40 && d == 0; i++) begin
         if (busy4) b++;
         if (done4) d++;
         @(negedge Clk);
      end
   endtask

   initial begin
      #12;
      check("rst_ab", {a8, b8}, 32'h0);
      check("rst_x_busy_done", {x8, busy8, done8}, 32'h0);
      @(negedge Clk);
      Reset = 0;
      @(negedge Clk);

      load8(8'hFF);
      check("load_b", b8, 32'hFF);
      run8(1'b0, 8'hFF, nb, nd);
      check("u_ff_busy", nb, 8);
      check("u_ff_done", nd, 1);
      check("u_ff_prod", {a8, b8}, 32'hFE01);

      c8 = 1;
      @(negedge Clk);
      c8 = 0;
      check("clear_a", {x8, a8, b8}, 32'h0001);

      load8(8'h07);
      run8(1'b1, 8'hC5, nb, nd);
      check("s_c5x07_prod", {a8, b8}, 32'hFE63);
      check("s_c5x07_x", x8, 1);
      run8(1'b1, 8'h02, nb, nd);
      check("s_chain_prod", {a8, b8}, 32'h00C6);
      check("s_chain_done", nd, 1);

      load8(8'h80);
      run8(1'b1, 8'h80, nb, nd);
      check("s_min_min", {a8, b8}, 32'h4000);
      load8(8'hFF);
      run8(1'b1, 8'hFF, nb, nd);
      check("s_m1_m1", {a8, b8}, 32'h0001);

      load8(8'h03);
      e8 = 1; d8 = 8'h05; sm8 = 0;
      nb = 0; nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (busy8) nb++;
         if (done8) nd++;
         if (i == 20) begin l8 = 1; d8 = 8'hAA; end
      end
      e8 = 0; l8 = 0;
      @(negedge Clk);
      check("held_done", nd, 1);
      check("held_busy", nb, 8);
      check("held_prod", {a8, b8}, 32'h000F);

      load8(8'h33);
      e8 = 1; d8 = 8'h11; sm8 = 0;
      @(negedge Clk);
      e8 = 0;
      @(negedge Clk);
      @(negedge Clk);
      #1 Reset = 1;
      #1;
      check("abort_regs", {x8, a8, b8}, 32'h0);
      check("abort_busy", busy8, 0);
      @(negedge Clk);
      Reset = 0;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         if (done8) nd++;
      end
      check("abort_no_done", nd, 0);
      load8(8'h0C);
      run8(1'b0, 8'h0D, nb, nd);
      check("after_abort_prod", {a8, b8}, 32'h009C);
      check("after_abort_busy", nb, 8);

      load4(4'h9);
      run4(1'b1, 4'h7, nb, nd);
      check("w4_s_prod", {a4, b4}, 32'hCF);
      check("w4_s_busy", nb, 4);
      load4(4'h9);
      run4(1'b0, 4'h7, nb, nd);
      check("w4_u_prod", {a4, b4}, 32'h3F);
      check("w4_u_done", nd, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
